// File: rtl/output_acc_buffer_if.sv
// Bus bundle for output_acc_buffer: write port, random-read port, drain
// control, output line handshake and status.
interface output_acc_buffer_if #(
   parameter int DATA_W = 32,
   parameter int LANES  = 16,
   parameter int DEPTH  = 64
) ();
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int LINE_W = LANES * DATA_W;

   logic              wr_en;
   logic              wr_ready;
   logic              wr_acc;
   logic [ADDR_W-1:0] wr_addr;
   logic [LINE_W-1:0] wr_data;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              drain_start;
   logic              out_valid;
   logic              out_ready;
   logic [LINE_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_last;
   logic              busy;
   logic [ADDR_W:0]   occupancy;
   logic              sat_flag;

   // Client side: issues writes/reads/drains and consumes output lines.
   modport master (
      output wr_en, wr_acc, wr_addr, wr_data, rd_en, rd_addr, drain_start, out_ready,
      input  wr_ready, out_valid, out_data, out_addr, out_last, busy, occupancy, sat_flag
   );

   // Buffer side.
   modport slave (
      input  wr_en, wr_acc, wr_addr, wr_data, rd_en, rd_addr, drain_start, out_ready,
      output wr_ready, out_valid, out_data, out_addr, out_last, busy, occupancy, sat_flag
   );
endinterface

// File: rtl/output_acc_buffer.sv
// Line buffer with overwrite / saturating-accumulate writes, random reads and
// an ordered drain of all valid lines through a single output register.
module output_acc_buffer #(
   parameter int DATA_W = 32,
   parameter int LANES  = 16,
   parameter int DEPTH  = 64,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   output_acc_buffer_if.slave bus
);
   localparam int LINE_W = LANES * DATA_W;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   localparam logic [DATA_W-1:0] LANE_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] LANE_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [ADDR_W:0]   OCC_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   // Line storage; contents are never reset, only the valid bitmap is.
   logic [LINE_W-1:0] mem [DEPTH];

   logic [0:0]        state_reg;
   logic [ADDR_W-1:0] ptr_reg;
   logic [DEPTH-1:0]  valid_reg;
   logic [ADDR_W:0]   occ_reg;
   logic              out_valid_reg;
   logic              out_last_reg;
   logic [LINE_W-1:0] out_data_reg;
   logic [ADDR_W-1:0] out_addr_reg;
   logic              sat_reg;

   logic              idle;
   logic              out_free;
   logic              out_accept;
   logic              wr_fire;
   logic              rd_fire;
   logic              ptr_valid;
   logic              drain_done;
   logic              drain_fire;
   logic              ptr_adv;
   logic              load;
   logic [ADDR_W-1:0] sel_addr;
   logic [LINE_W-1:0] sel_line;
   logic [LINE_W-1:0] old_line;
   logic [LINE_W-1:0] acc_line;
   logic [LINE_W-1:0] new_line;
   logic [LANES-1:0]  lane_sat;
   logic [DEPTH-1:0]  above_mask;

   assign idle       = (state_reg == ST_IDLE);
   assign out_free   = !out_valid_reg || bus.out_ready;
   assign out_accept = out_valid_reg && bus.out_ready;

   // Writes are only taken in IDLE; drain_start does not block a same-cycle write.
   assign wr_fire = idle && bus.wr_en;
   // drain_start wins over a same-cycle random read.
   assign rd_fire = idle && bus.rd_en && !bus.drain_start && out_free;

   assign ptr_valid = valid_reg[ptr_reg];

   // Drain finishes when its last line is taken, or straight away if nothing is stored.
   assign drain_done = !idle &&
                       ((out_accept && out_last_reg) ||
                        ((occ_reg == '0) && !(out_valid_reg && out_last_reg)));
   assign drain_fire = !idle && !drain_done && ptr_valid && out_free;
   // Skip empty lines freely; stall on a valid line until the output register frees up.
   assign ptr_adv    = !idle && !drain_done && (occ_reg != '0) && (!ptr_valid || out_free);

   assign load     = rd_fire || drain_fire;
   assign sel_addr = idle ? bus.rd_addr : ptr_reg;
   // Invalid lines read back as zero; mem is read before any same-edge write lands.
   assign sel_line = valid_reg[sel_addr] ? mem[sel_addr] : '0;

   // Accumulation treats an invalid line as all-zero.
   assign old_line = valid_reg[bus.wr_addr] ? mem[bus.wr_addr] : '0;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_W-1:0] old_lane;
      logic [DATA_W-1:0] in_lane;
      logic [DATA_W:0]   sum;

      assign old_lane = old_line[gi*DATA_W +: DATA_W];
      assign in_lane  = bus.wr_data[gi*DATA_W +: DATA_W];
      // One guard bit: the sum overflowed iff the top two bits disagree.
      assign sum          = {old_lane[DATA_W-1], old_lane} + {in_lane[DATA_W-1], in_lane};
      assign lane_sat[gi] = sum[DATA_W] ^ sum[DATA_W-1];
      assign acc_line[gi*DATA_W +: DATA_W] =
         !lane_sat[gi] ? sum[DATA_W-1:0] : (sum[DATA_W] ? LANE_MIN : LANE_MAX);
   end

   assign new_line = bus.wr_acc ? acc_line : bus.wr_data;

   // Valid lines strictly above the drain pointer; none left means this is the last line.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_above
      localparam logic [ADDR_W-1:0] LINE_IDX = ADDR_W'(gi);
      assign above_mask[gi] = valid_reg[gi] && (LINE_IDX > ptr_reg);
   end

   // FSM and drain scan pointer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         ptr_reg   <= '0;
      end else if (idle) begin
         if (bus.drain_start) begin
            state_reg <= ST_DRAIN;
            ptr_reg   <= '0;
         end
      end else if (drain_done) begin
         state_reg <= ST_IDLE;
      end else if (ptr_adv) begin
         ptr_reg <= ptr_reg + PTR_ONE;
      end
   end

   // Valid bitmap and occupancy; writes and drain loads never coincide.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_reg <= '0;
         occ_reg   <= '0;
      end else if (wr_fire) begin
         valid_reg[bus.wr_addr] <= 1'b1;
         if (!valid_reg[bus.wr_addr]) begin
            occ_reg <= occ_reg + OCC_ONE;
         end
      end else if (drain_fire) begin
         valid_reg[ptr_reg] <= 1'b0;
         occ_reg            <= occ_reg - OCC_ONE;
      end
   end

   // Line storage write port.
   always_ff @(posedge clk) begin
      if (rst && wr_fire) begin
         mem[bus.wr_addr] <= new_line;
      end
   end

   // Output register: loads from a read or drain, holds until accepted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         out_data_reg  <= '0;
         out_addr_reg  <= '0;
      end else if (load) begin
         out_valid_reg <= 1'b1;
         out_addr_reg  <= sel_addr;
         out_data_reg  <= sel_line;
         out_last_reg  <= drain_fire ? ~|above_mask : 1'b0;
      end else if (out_accept) begin
         out_valid_reg <= 1'b0;
      end
   end

   // Sticky saturation flag, raised only by accumulating writes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sat_reg <= 1'b0;
      end else if (wr_fire && bus.wr_acc && (|lane_sat)) begin
         sat_reg <= 1'b1;
      end
   end

   assign bus.wr_ready  = idle;
   assign bus.busy      = !idle;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_data  = out_data_reg;
   assign bus.out_addr  = out_addr_reg;
   assign bus.out_last  = out_last_reg;
   assign bus.occupancy = occ_reg;
   assign bus.sat_flag  = sat_reg;
endmodule

// File: tb/tb_output_acc_buffer.sv
// Self-checking bench for output_acc_buffer: directed scenarios with literal
// expectations plus randomized traffic against a lane-level reference model.
module tb_output_acc_buffer;
   localparam int DATA_W = 32;
   localparam int LANES  = 16;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int LINE_W = LANES * DATA_W;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   output_acc_buffer_if #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) bus_i ();

   output_acc_buffer #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state, kept as plain lane integers.
   int m_mem   [DEPTH][LANES];
   bit m_valid [DEPTH];
   int m_od    [LANES];
   bit m_ov, m_ol, m_busy, m_sat, m_known;
   int m_oa, m_ptr;

   int acc_addr_q[$];
   bit acc_last_q[$];

   task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int m_count();
      int c = 0;
      for (int a = 0; a < DEPTH; a++) c += int'(m_valid[a]);
      return c;
   endfunction

   function automatic logic [LINE_W-1:0] m_flat();
      logic [LINE_W-1:0] r;
      for (int l = 0; l < LANES; l++) r[l*DATA_W +: DATA_W] = m_od[l];
      return r;
   endfunction

   task automatic m_load(input int a);
      m_ov = 1'b1;
      m_oa = a;
      for (int l = 0; l < LANES; l++) m_od[l] = m_valid[a] ? m_mem[a][l] : 0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      bit accept, was_ov, any_above;
      longint s;
      int a, v;
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
         for (int l = 0; l < LANES; l++) m_od[l] = 0;
         m_ov = 0; m_ol = 0; m_busy = 0; m_sat = 0; m_oa = 0; m_ptr = 0;
         m_known = 1'b1;
         return;
      end
      if (!m_known) return;
      was_ov = m_ov;
      accept = m_ov && bus_i.out_ready;
      if (accept) m_ov = 1'b0;
      if (!m_busy) begin
         if (bus_i.rd_en && !bus_i.drain_start && (!was_ov || bus_i.out_ready)) begin
            m_load(int'(bus_i.rd_addr));
            m_ol = 1'b0;
         end
         if (bus_i.wr_en) begin
            a = int'(bus_i.wr_addr);
            for (int l = 0; l < LANES; l++) begin
               v = $signed(bus_i.wr_data[l*DATA_W +: DATA_W]);
               if (bus_i.wr_acc) begin
                  s = longint'(m_valid[a] ? m_mem[a][l] : 0) + longint'(v);
                  if (s > 64'sd2147483647) begin s = 64'sd2147483647; m_sat = 1'b1; end
                  if (s < -64'sd2147483648) begin s = -64'sd2147483648; m_sat = 1'b1; end
                  m_mem[a][l] = int'(s);
               end else begin
                  m_mem[a][l] = v;
               end
            end
            m_valid[a] = 1'b1;
         end
         if (bus_i.drain_start) begin
            m_busy = 1'b1;
            m_ptr  = 0;
         end
      end else if ((accept && m_ol) || (m_count() == 0 && !(was_ov && m_ol))) begin
         m_busy = 1'b0;
      end else if (m_ptr < DEPTH) begin
         if (!m_valid[m_ptr]) begin
            m_ptr++;
         end else if (!was_ov || bus_i.out_ready) begin
            m_load(m_ptr);
            any_above = 1'b0;
            for (int i = m_ptr + 1; i < DEPTH; i++) any_above |= m_valid[i];
            m_ol = !any_above;
            m_valid[m_ptr] = 1'b0;
            m_ptr++;
         end
      end
   endtask

   task automatic compare();
      if (!m_known) return;
      chk("out_valid", LINE_W'(bus_i.out_valid), LINE_W'(m_ov));
      chk("busy", LINE_W'(bus_i.busy), LINE_W'(m_busy));
      chk("wr_ready", LINE_W'(bus_i.wr_ready), LINE_W'(!m_busy));
      chk("occupancy", LINE_W'(bus_i.occupancy), LINE_W'(m_count()));
      chk("sat_flag", LINE_W'(bus_i.sat_flag), LINE_W'(m_sat));
      if (m_ov) begin
         chk("out_addr", LINE_W'(bus_i.out_addr), LINE_W'(m_oa));
         chk("out_last", LINE_W'(bus_i.out_last), LINE_W'(m_ol));
         chk("out_data", bus_i.out_data, m_flat());
      end
   endtask

   // One clock: compare mid-cycle, step the model, then return just after the edge.
   task automatic step();
      @(negedge clk);
      compare();
      if (bus_i.out_valid && bus_i.out_ready) begin
         acc_addr_q.push_back(int'(bus_i.out_addr));
         acc_last_q.push_back(bus_i.out_last);
      end
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus_i.wr_en = 0; bus_i.wr_acc = 0; bus_i.wr_addr = '0; bus_i.wr_data = '0;
      bus_i.rd_en = 0; bus_i.rd_addr = '0; bus_i.drain_start = 0; bus_i.out_ready = 1;
   endtask

   task automatic do_write(input bit acc, input int a, input logic [LINE_W-1:0] d);
      quiet();
      bus_i.wr_en = 1; bus_i.wr_acc = acc; bus_i.wr_addr = ADDR_W'(a); bus_i.wr_data = d;
      step();
   endtask

   task automatic do_read(input int a);
      quiet();
      bus_i.rd_en = 1; bus_i.rd_addr = ADDR_W'(a);
      step();
   endtask

   task automatic do_reset();
      quiet();
      rst = 0;
      step();
      rst = 1;
   endtask

   function automatic logic [LINE_W-1:0] rnd_line();
      logic [LINE_W-1:0] r;
      for (int l = 0; l < LANES; l++) begin
         case ($urandom_range(0, 3))
            0:       r[l*DATA_W +: DATA_W] = 32'h7FFF_FF00 | 32'($urandom_range(0, 255));
            1:       r[l*DATA_W +: DATA_W] = 32'h8000_0000 | 32'($urandom_range(0, 255));
            default: r[l*DATA_W +: DATA_W] = $urandom;
         endcase
      end
      return r;
   endfunction

   logic [LINE_W-1:0] line_v;
   int busy_cycles, ov_seen, iter;

   initial begin
      checks = 0; failures = 0; m_known = 0;
      quiet();
      rst = 0;
      step(); step();
      rst = 1;
      chk("rst_out_valid", LINE_W'(bus_i.out_valid), '0);
      chk("rst_out_data", bus_i.out_data, '0);
      chk("rst_out_addr", LINE_W'(bus_i.out_addr), '0);
      chk("rst_out_last", LINE_W'(bus_i.out_last), '0);
      chk("rst_occupancy", LINE_W'(bus_i.occupancy), '0);
      chk("rst_busy", LINE_W'(bus_i.busy), '0);
      chk("rst_sat", LINE_W'(bus_i.sat_flag), '0);

      // Accumulate into an empty line.
      line_v = '0; line_v[31:0] = 32'd5;
      do_write(1, 3, line_v);
      do_read(3);
      chk("acc_empty_lane0", LINE_W'(bus_i.out_data[31:0]), LINE_W'(32'd5));
      chk("acc_empty_occ", LINE_W'(bus_i.occupancy), LINE_W'(1));

      // Saturation and sticky flag.
      line_v = '0; line_v[31:0] = 32'h7FFF_FFF0;
      do_write(0, 1, line_v);
      chk("ovr_no_sat", LINE_W'(bus_i.sat_flag), '0);
      line_v[31:0] = 32'h20;
      do_write(1, 1, line_v);
      do_read(1);
      chk("sat_lane0", LINE_W'(bus_i.out_data[31:0]), LINE_W'(32'h7FFF_FFFF));
      chk("sat_flag_set", LINE_W'(bus_i.sat_flag), LINE_W'(1));
      line_v[31:0] = 32'h1;
      do_write(0, 1, line_v);
      step();
      chk("sat_flag_sticky", LINE_W'(bus_i.sat_flag), LINE_W'(1));

      // Same-cycle overwrite and read of one line.
      line_v = '0; line_v[31:0] = 32'd9;
      do_write(0, 4, line_v);
      quiet();
      line_v[31:0] = 32'd1;
      bus_i.wr_en = 1; bus_i.wr_addr = ADDR_W'(4); bus_i.wr_data = line_v;
      bus_i.rd_en = 1; bus_i.rd_addr = ADDR_W'(4);
      step();
      chk("collide_old", LINE_W'(bus_i.out_data[31:0]), LINE_W'(32'd9));
      do_read(4);
      chk("collide_new", LINE_W'(bus_i.out_data[31:0]), LINE_W'(32'd1));

      // Drain of lines 2, 7, 63 with out_ready toggling.
      do_reset();
      do_write(0, 2, rnd_line());
      do_write(0, 7, rnd_line());
      do_write(0, 63, rnd_line());
      acc_addr_q.delete(); acc_last_q.delete();
      quiet();
      bus_i.drain_start = 1;
      step();
      quiet();
      iter = 0;
      while (iter < 300 && !(acc_addr_q.size() == 3 && !bus_i.busy)) begin
         bus_i.out_ready = iter[0];
         step();
         iter++;
      end
      quiet();
      chk("drain_timeout", LINE_W'(iter < 300), LINE_W'(1));
      chk("drain_count", LINE_W'(acc_addr_q.size()), LINE_W'(3));
      if (acc_addr_q.size() == 3) begin
         chk("drain_addr0", LINE_W'(acc_addr_q[0]), LINE_W'(2));
         chk("drain_addr1", LINE_W'(acc_addr_q[1]), LINE_W'(7));
         chk("drain_addr2", LINE_W'(acc_addr_q[2]), LINE_W'(63));
         chk("drain_last", LINE_W'({acc_last_q[0], acc_last_q[1], acc_last_q[2]}), LINE_W'(3'b001));
      end
      chk("drain_occ", LINE_W'(bus_i.occupancy), '0);
      chk("drain_busy", LINE_W'(bus_i.busy), '0);

      // Empty drain: one busy cycle, no output.
      step(); step();
      bus_i.drain_start = 1;
      step();
      quiet();
      busy_cycles = int'(bus_i.busy);
      ov_seen = int'(bus_i.out_valid);
      for (int i = 0; i < 5; i++) begin
         step();
         busy_cycles += int'(bus_i.busy);
         ov_seen += int'(bus_i.out_valid);
      end
      chk("empty_busy_cycles", LINE_W'(busy_cycles), LINE_W'(1));
      chk("empty_no_out", LINE_W'(ov_seen), '0);

      // Reset mid-drain; a write during the drain is dropped.
      do_write(0, 10, rnd_line());
      do_write(0, 20, rnd_line());
      quiet();
      bus_i.out_ready = 0; bus_i.drain_start = 1;
      step();
      quiet();
      bus_i.out_ready = 0;
      step(); step();
      bus_i.wr_en = 1; bus_i.wr_addr = ADDR_W'(30); bus_i.wr_data = rnd_line();
      #1;
      chk("drain_wr_ready", LINE_W'(bus_i.wr_ready), '0);
      step();
      do_reset();
      do_read(20);
      chk("rst_drain_zero", bus_i.out_data, '0);
      chk("rst_drain_occ", LINE_W'(bus_i.occupancy), '0);
      do_read(30);
      chk("dropped_write", bus_i.out_data, '0);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         quiet();
         rst = ($urandom_range(0, 199) != 0);
         bus_i.wr_en   = ($urandom_range(0, 9) < 4);
         bus_i.wr_acc  = $urandom_range(0, 1);
         bus_i.wr_addr = ADDR_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7));
         bus_i.wr_data = rnd_line();
         bus_i.rd_en   = ($urandom_range(0, 9) < 3);
         bus_i.rd_addr = ADDR_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7));
         bus_i.drain_start = ($urandom_range(0, 99) < 3);
         bus_i.out_ready   = ($urandom_range(0, 9) < 7);
         if (bus_i.drain_start && !m_busy && m_count() == 0) bus_i.wr_en = 0;
         step();
      end
      rst = 1;
      quiet();
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/output_acc_buffer.md
OUTPUT_ACC_BUFFER -- requirements
Module: output_acc_buffer

Interface
REQ-001 Parameter DATA_W, default 32: bits per lane element, two's-complement signed.
REQ-002 Parameter LANES, default 16: elements per line.
REQ-003 Parameter DEPTH, default 64: lines stored; ADDR_W = clog2(DEPTH).
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-low.
REQ-006 wr_en  in  1  write request.
REQ-007 wr_ready  out  1  write accepted this cycle; equals !busy.
REQ-008 wr_acc  in  1  0 = overwrite line, 1 = accumulate into line.
REQ-009 wr_addr  in  ADDR_W  write line index.
REQ-010 wr_data  in  LANES*DATA_W  write line; lane i at bits [i*DATA_W +: DATA_W].
REQ-011 rd_en  in  1  random-read request.
REQ-012 rd_addr  in  ADDR_W  read line index.
REQ-013 drain_start  in  1  start a drain of all valid lines.
REQ-014 out_valid  out  1  output register holds a line.
REQ-015 out_ready  in  1  consumer accepts the output line.
REQ-016 out_data  out  LANES*DATA_W  output line.
REQ-017 out_addr  out  ADDR_W  line index of out_data.
REQ-018 out_last  out  1  final line of a drain; 0 for random reads.
REQ-019 busy  out  1  high while state is DRAIN.
REQ-020 occupancy  out  ADDR_W+1  count of valid lines.
REQ-021 sat_flag  out  1  sticky; set on any lane saturation.

Function
REQ-022 Storage: DEPTH lines of LANES*DATA_W plus a DEPTH-bit valid bitmap; the valid bitmap is the only cleared state.
REQ-023 FSM states: IDLE and DRAIN; IDLE->DRAIN on drain_start; DRAIN->IDLE when the line flagged out_last is accepted, or one cycle after drain_start with occupancy 0.
REQ-024 Write in IDLE with wr_en: the line is updated at the next edge and the valid bit set; occupancy increments only if the line was previously invalid.
REQ-025 Accumulate: each lane = old + wr_data, where old = 0 if the line is invalid; signed saturation to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; sat_flag is set if any lane clamps.
REQ-026 Overwrite never saturates and never sets sat_flag.
REQ-027 wr_en while busy is dropped with no state change (wr_ready = 0).
REQ-028 Random read in IDLE: rd_en with (!out_valid or out_ready) loads the output register next cycle: out_valid = 1, out_addr = rd_addr, out_last = 0, out_data = line, or all zeros if invalid; the valid bit is unchanged.
REQ-029 rd_en while out_valid && !out_ready, or while busy, is ignored.
REQ-030 Same-cycle write and read to the same address: the read returns the pre-write value.
REQ-031 The output register holds out_data, out_addr and out_last stable until out_valid && out_ready; out_valid falls after acceptance unless it is reloaded the same cycle.
REQ-032 drain_start has priority over rd_en in the same cycle; a write in the same cycle is still accepted, because busy is 0 that cycle.
REQ-033 DRAIN: the scan pointer starts at 0 and advances one address per cycle past invalid lines.
REQ-034 DRAIN, valid line at the pointer: it is loaded into the output register when the register is free or being accepted, its valid bit is cleared, and occupancy decrements.
REQ-035 out_last = 1 when no valid bit exists above the loaded address.
REQ-036 Drain output has latency 1 cycle from the load decision; back-to-back valid lines stream one per cycle when out_ready is held high.
REQ-037 drain_start while busy is ignored.
REQ-038 Reads and drains are lane-order preserving; no lane reordering anywhere.

Reset
REQ-039 With rst = 0 at a clock edge: state = IDLE, valid bitmap = 0, occupancy = 0, out_valid = 0, out_last = 0, out_data = 0, out_addr = 0, sat_flag = 0, busy = 0, scan pointer = 0.
REQ-040 Reset mid-drain aborts the drain and discards the pending output line; line contents are don't-care after reset.

Verification
REQ-041 Accumulate on an empty line: write acc, lane0 = 5, to addr 3; read addr 3 -> out_data lane0 = 5 one cycle later; occupancy = 1.
REQ-042 Saturation: overwrite lane0 = 0x7FFFFFF0 at addr 1, then accumulate 0x20 -> lane0 = 0x7FFFFFFF and sat_flag = 1; sat_flag stays 1 after a later overwrite.
REQ-043 Drain with backpressure: valid lines at 2, 7 and 63; drain_start with out_ready toggling -> out_addr sequence 2, 7, 63; out_last only on 63; then occupancy = 0 and busy = 0.
REQ-044 Empty drain: drain_start with occupancy 0 -> busy high for 1 cycle, out_valid never asserts.
REQ-045 Collision: same-cycle overwrite and read of addr 4 (old lane0 = 9, new lane0 = 1) -> read returns 9; next read returns 1.
REQ-046 Reset mid-drain, then read of a previously valid line -> zeros, occupancy = 0, and a write during the drain is dropped.
